core_sequencer: RTL

- Multi-cycle sequencer for the RV32I single-issue datapath.
- Sits between the instruction decoder (control signals), instruction/data memories (req/ack handshake), PC register, instruction register and register file write port.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB, qualifies every state-changing strobe, and traps on illegal instructions or memory timeouts.
- Keeps a retired-instruction counter.

---
 rtl/core_sequencer_pkg.sv | 5 +
 rtl/core_sequencer_if.sv | 6 +
 rtl/core_sequencer_mem_timeout.sv | 18 +
 rtl/core_sequencer.sv | 89 ++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
// core_sequencer_pkg: state encodings and trap cause codes shared by the sequencer files
package core_sequencer_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WB, ST_TRAP} state_t;
  typedef enum logic [1:0] {TRAP_NONE, TRAP_ILL, TRAP_IMEM, TRAP_DMEM} trap_t;
endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction/data memory req/ack handshake bundle
interface core_sequencer_if;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  modport master(output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave(input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/core_sequencer_mem_timeout.sv
// core_sequencer_mem_timeout: saturating wait counter shared by FETCH and MEM
module core_sequencer_mem_timeout #(
  parameter int W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign hit = cnt == W'(LIMIT - 1);
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I sequencer walking FETCH/DECODE/EXECUTE/MEM/WB with traps
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  core_sequencer_if.master      bus,
  output logic                  ir_load,
  input  logic                  branch_enable,
  input  logic                  mem_write_enable,
  input  logic                  reg_write_enable,
  input  logic                  mem_to_reg,
  input  logic                  ill_instr,
  input  logic                  branch_cond,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  rf_write,
  output logic                  halted,
  output logic [1:0]            trap_cause,
  output logic [31:0]           instret
);
  state_t st, st_n;
  trap_t cause, cause_n;
  logic waiting, ack, tmo;
  assign waiting = st == ST_FETCH || st == ST_MEM;
  assign ack = st == ST_FETCH ? bus.imem_ack : st == ST_MEM && bus.dmem_ack;
  // clear dominates, so an ack on the limit cycle restarts the count instead of trapping
  core_sequencer_mem_timeout #(.W(TIMEOUT_W), .LIMIT(MEM_TIMEOUT)) u_tmo (
    .clk(clk), .rst_n(rst_n), .clr(!waiting || ack), .en(waiting), .hit(tmo)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      cause <= TRAP_NONE;
    end else begin
      st <= st_n;
      cause <= cause_n;
    end
  always_comb begin
    st_n = st;
    cause_n = cause;
    case (st)
      ST_IDLE: st_n = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:
        if (ack) st_n = ST_DECODE;
        else if (tmo) begin
          st_n = ST_TRAP;
          cause_n = TRAP_IMEM;
        end
      ST_DECODE:
        if (ill_instr) begin
          st_n = ST_TRAP;
          cause_n = TRAP_ILL;
        end else st_n = ST_EXECUTE;
      ST_EXECUTE: st_n = mem_to_reg || mem_write_enable ? ST_MEM : branch_enable ? ST_FETCH : ST_WB;
      ST_MEM:
        if (ack) st_n = mem_to_reg ? ST_WB : ST_FETCH;
        else if (tmo) begin
          st_n = ST_TRAP;
          cause_n = TRAP_DMEM;
        end
      ST_WB: st_n = ST_FETCH;
      default: st_n = ST_TRAP;
    endcase
  end
  always_comb begin
    bus.imem_req = st == ST_FETCH;
    bus.dmem_req = st == ST_MEM;
    bus.dmem_we = st == ST_MEM && mem_write_enable;
    ir_load = st == ST_FETCH && bus.imem_ack;
    pc_write = st == ST_WB
             || (st == ST_EXECUTE && !mem_to_reg && !mem_write_enable && branch_enable)
             || (st == ST_MEM && bus.dmem_ack && !mem_to_reg);
    pc_src = pc_write && st == ST_EXECUTE && branch_cond;
    rf_write = st == ST_WB && reg_write_enable;
    halted = st == ST_TRAP;
    trap_cause = cause;
  end
  // every pc_write marks exactly one completed instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instret <= '0;
    else if (pc_write) instret <= instret + 1'b1;
  assert property (@(posedge clk) disable iff (!rst_n)
    ((bus.imem_req && !bus.imem_ack) || (bus.dmem_req && !bus.dmem_ack)) |-> !(pc_write || rf_write || ir_load));
endmodule
